fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter and drives the instruction memory address combinationally from it. It captures the returned word together with PC+4 into the IF/ID pipeline register. It applies hazard freezes from the hazard unit and branch redirects/flushes from EX.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// Optional valid-fetch counter and fetch_count port are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          INST_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [ADDR_SIZE-1:0] branch_addr,
  input  logic                 flush,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [INST_SIZE-1:0] imem_inst,
  output logic [ADDR_SIZE-1:0] if_id_pc,
  output logic [INST_SIZE-1:0] if_id_inst,
  output logic                 if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  localparam logic [ADDR_SIZE-1:0] PC_STEP    = ADDR_SIZE'(4);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(3);

  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] pc_d;
  logic [ADDR_SIZE-1:0] pc_plus4_c;
  logic [ADDR_SIZE-1:0] if_id_pc_d;
  logic [INST_SIZE-1:0] if_id_inst_d;
  logic                 if_id_valid_d;
  logic                 kill_c;
  logic                 load_c;

  // Next-state selection: branch beats freeze; flush only affects IF/ID.
  always_comb begin
    pc_plus4_c    = pc_q + PC_STEP;
    kill_c        = branch_taken | flush;
    load_c        = !kill_c && !freeze;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc;
    if_id_inst_d  = if_id_inst;
    if_id_valid_d = if_id_valid;

    if (branch_taken) begin
      pc_d = branch_addr & ALIGN_MASK;
    end else if (!freeze) begin
      pc_d = pc_plus4_c;
    end

    if (kill_c) begin
      if_id_pc_d    = '0;
      if_id_inst_d  = '0;
      if_id_valid_d = 1'b0;
    end else if (load_c) begin
      if_id_pc_d    = pc_plus4_c;
      if_id_inst_d  = imem_inst;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
      if_id_valid <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if_id_pc    <= if_id_pc_d;
      if_id_inst  <= if_id_inst_d;
      if_id_valid <= if_id_valid_d;
    end
  end

  assign imem_addr = pc_q;

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] fetch_cnt_q;

  // Saturating count of edges that load a valid instruction into IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if (load_c && (fetch_cnt_q != '1)) begin
      fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end
  end

  assign fetch_count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, literal expectations and a
// per-cycle comparison against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned AW  = 32;
  localparam int unsigned IW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          freeze;
  logic          branch_taken;
  logic [AW-1:0] branch_addr;
  logic          flush;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_inst;
  logic [AW-1:0] if_id_pc;
  logic [IW-1:0] if_id_inst;
  logic          if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_SIZE(AW), .INST_SIZE(IW), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .flush        (flush),
    .imem_addr    (imem_addr),
    .imem_inst    (imem_inst),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds i+1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a / 32'd4) + 32'd1;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  // Behavioural model of the stage.
  logic [31:0] m_pc    = RPC;
  logic [31:0] m_ipc   = '0;
  logic [31:0] m_inst  = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = RPC;
      m_ipc   = '0;
      m_inst  = '0;
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (branch_taken || flush) begin
        m_inst  = '0;
        m_ipc   = '0;
        m_valid = 1'b0;
      end else if (!freeze) begin
        m_inst  = mem_word(m_pc);
        m_ipc   = m_pc + 32'd4;
        m_valid = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (branch_taken)  m_pc = (branch_addr / 32'd4) * 32'd4;
      else if (!freeze)  m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_if_id_pc", if_id_pc, m_ipc);
      chk("model_if_id_inst", if_id_inst, m_inst);
      chk("model_if_id_valid", 32'(if_id_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      chk("model_fetch_count", fetch_count, m_cnt);
`endif
    end
  end

  task automatic lit(input logic [31:0] e_addr, input logic [31:0] e_inst,
                     input logic [31:0] e_ipc, input logic e_valid);
    chk("lit_imem_addr", imem_addr, e_addr);
    chk("lit_if_id_inst", if_id_inst, e_inst);
    chk("lit_if_id_pc", if_id_pc, e_ipc);
    chk("lit_if_id_valid", 32'(if_id_valid), 32'(e_valid));
  endtask

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic cyc(input logic br, input logic [31:0] ba, input logic fl, input logic fz);
    branch_taken = br;
    branch_addr  = ba;
    flush        = fl;
    freeze       = fz;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 lit(RPC, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset_fetch_count", fetch_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    flush        = 1'b0;
    #2 lit(RPC, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Linear fetch from reset.
    cyc(0, 0, 0, 0); lit(32'd4,  32'd1, 32'd4,  1'b1);
    cyc(0, 0, 0, 0); lit(32'd8,  32'd2, 32'd8,  1'b1);
    cyc(0, 0, 0, 0); lit(32'd12, 32'd3, 32'd12, 1'b1);

    // Return to PC=8 then freeze for 3 edges.
    cyc(1, 32'd4, 0, 0); lit(32'd4, 32'd0, 32'd0, 1'b0);
    cyc(0, 0, 0, 0);     lit(32'd8, 32'd2, 32'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1); lit(32'd8, 32'd2, 32'd8, 1'b1);
    end
    cyc(0, 0, 0, 0); lit(32'd12, 32'd3, 32'd12, 1'b1);

    // Branch plus freeze with a misaligned target.
    cyc(1, 32'h20, 0, 0);  lit(32'h20,  32'h0,  32'h0,   1'b0);
    cyc(1, 32'h103, 0, 1); lit(32'h100, 32'h0,  32'h0,   1'b0);
    cyc(0, 0, 0, 0);       lit(32'h104, 32'h41, 32'h104, 1'b1);

    // Flush plus freeze: PC holds, IF/ID bubbles.
    cyc(1, 32'h40, 0, 0); lit(32'h40, 32'h0,  32'h0,  1'b0);
    cyc(0, 0, 1, 1);      lit(32'h40, 32'h0,  32'h0,  1'b0);
    cyc(0, 0, 0, 0);      lit(32'h44, 32'h11, 32'h44, 1'b1);

    // Branch plus flush behaves as branch alone.
    cyc(1, 32'h80, 1, 0); lit(32'h80, 32'h0,  32'h0,  1'b0);
    cyc(0, 0, 0, 0);      lit(32'h84, 32'h21, 32'h84, 1'b1);

    // PC wrap at the top of the address space.
    cyc(1, 32'hFFFF_FFFE, 0, 0); lit(32'hFFFF_FFFC, 32'h0,         32'h0, 1'b0);
    cyc(0, 0, 0, 0);             lit(32'h0,         32'h4000_0000, 32'h0, 1'b1);
    cyc(0, 0, 0, 0);             lit(32'h4,         32'h1,         32'h4, 1'b1);

    // Mixed control patterns, checked against the model.
    cyc(0, 0, 1, 0);
    cyc(1, 32'h200, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h13, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset between edges, then first fetch from RESET_PC.
    reset_pulse();
    cyc(0, 0, 0, 0); lit(RPC + 32'd4, mem_word(RPC), RPC + 32'd4, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    reset_pulse();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    chk("perf_count_5", fetch_count, 32'd5);
    #2;
    force dut.fetch_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.fetch_cnt_q;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("perf_count_sat", fetch_count, 32'hFFFF_FFFF);
`endif

    cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
